// File: rtl/div32_iter_u5_gznk_pkg.sv
// Shared definitions for the iterative restoring divider.
// Optional macro DIV32_SIGNED_EN (used by the top) enables two's-complement division.
package div_pkg;

  localparam int DIV_DATA_W = 32;
  localparam int DIV_USR_W  = 5;
  localparam int DIV_CNT_W  = $clog2(DIV_DATA_W);

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div32_iter_u5_gznk_step.sv
// One radix-2 restoring division step: shift the next dividend bit into the
// partial remainder, compare against the divisor, conditionally subtract.
module div32_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] quo_i,
  input  logic [W-1:0] div_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] quo_o
);

  logic [W:0]   shifted;
  logic [W-1:0] diff;

  // Shifted remainder is W+1 bits so the compare never overflows; when it is
  // >= divisor the difference is < 2^W, so W bits suffice for the subtraction.
  always_comb begin
    shifted = {rem_i, quo_i[W-1]};
    diff    = shifted[W-1:0] - div_i;
    rem_o   = shifted[W-1:0];
    quo_o   = {quo_i[W-2:0], 1'b0};
    if (shifted >= {1'b0, div_i}) begin
      rem_o    = diff;
      quo_o[0] = 1'b1;
    end
  end

endmodule

// File: rtl/div32_iter_u5_gznk.sv
// Iterative 32-bit restoring divider, fixed latency DATA_W+1 cycles, one op in flight.
// Define DIV32_SIGNED_EN to add the io_signed input and two's-complement division.
//
// state    | meaning
// DIV_IDLE | ready, waiting for io_in_en
// DIV_CALC | DATA_W restoring steps, counter DATA_W-1 down to 0
// DIV_DONE | result valid (io_out_en), returns to IDLE after one unstalled cycle
module div32_iter_u5_gznk
  import div_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W,
  parameter int USR_W  = DIV_USR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_stop,
  input  logic [DATA_W-1:0] io_in1,
  input  logic [DATA_W-1:0] io_in2,
  input  logic [USR_W-1:0]  io_in_usr,
  input  logic              io_in_en,
`ifdef DIV32_SIGNED_EN
  input  logic              io_signed,
`endif
  output logic              io_in_rdy,
  output logic [DATA_W-1:0] io_result_l,
  output logic [DATA_W-1:0] io_result_h,
  output logic [USR_W-1:0]  io_out_usr,
  output logic              io_out_en
);

  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d, quo_q, quo_d, div_q, div_d;
  logic [USR_W-1:0]  usr_q, usr_d, out_usr_q, out_usr_d;
  logic              qneg_q, qneg_d, rneg_q, rneg_d;
  logic [DATA_W-1:0] res_l_q, res_l_d, res_h_q, res_h_d;
  logic [DATA_W-1:0] step_rem, step_quo;
  logic [DATA_W-1:0] in1_mag, in2_mag;
  logic              signed_op, accept;

`ifdef DIV32_SIGNED_EN
  assign signed_op = io_signed;
`else
  assign signed_op = 1'b0;
`endif

  assign accept  = (state_q == DIV_IDLE) && io_in_en && !io_stop;
  assign in1_mag = (signed_op && io_in1[DATA_W-1]) ? (~io_in1 + 1'b1) : io_in1;
  assign in2_mag = (signed_op && io_in2[DATA_W-1]) ? (~io_in2 + 1'b1) : io_in2;

  div32_step #(.W(DATA_W)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (div_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= DIV_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a stall holds the current state
  always_comb begin
    state_d = state_q;
    if (!io_stop) begin
      case (state_q)
        DIV_IDLE: if (io_in_en) state_d = DIV_CALC;
        DIV_CALC: if (cnt_q == '0) state_d = DIV_DONE;
        DIV_DONE: state_d = DIV_IDLE;
        default:  state_d = DIV_IDLE;
      endcase
    end
  end

  // State-decoded handshake outputs
  always_comb begin
    io_in_rdy = (state_q == DIV_IDLE);
    io_out_en = (state_q == DIV_DONE);
  end

  // Datapath next values: capture magnitudes on accept, iterate in CALC, fix signs on last step.
  // A zero divisor never negates the quotient so it stays all-ones in both modes.
  always_comb begin
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    usr_d     = usr_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    res_l_d   = res_l_q;
    res_h_d   = res_h_q;
    out_usr_d = out_usr_q;
    if (accept) begin
      rem_d  = '0;
      quo_d  = in1_mag;
      div_d  = in2_mag;
      cnt_d  = CNT_LAST;
      usr_d  = io_in_usr;
      qneg_d = signed_op && (io_in2 != '0) && (io_in1[DATA_W-1] ^ io_in2[DATA_W-1]);
      rneg_d = signed_op && io_in1[DATA_W-1];
    end else if (!io_stop && state_q == DIV_CALC) begin
      rem_d = step_rem;
      quo_d = step_quo;
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        res_l_d   = qneg_q ? (~step_quo + 1'b1) : step_quo;
        res_h_d   = rneg_q ? (~step_rem + 1'b1) : step_rem;
        out_usr_d = usr_q;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      usr_q     <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      res_l_q   <= '0;
      res_h_q   <= '0;
      out_usr_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      div_q     <= div_d;
      usr_q     <= usr_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      res_l_q   <= res_l_d;
      res_h_q   <= res_h_d;
      out_usr_q <= out_usr_d;
    end
  end

  assign io_result_l = res_l_q;
  assign io_result_h = res_h_q;
  assign io_out_usr  = out_usr_q;

endmodule
